// File: rtl/spi_target_regs.sv
// SPI mode-0 target with a small burst-accessible register file. SPI pins are
// oversampled in the system clock domain; byte 0 is the command (RW + address).
module spi_target_regs #(
  parameter int unsigned ADDR_W    = 2,
  parameter logic [7:0]  ID_BYTE   = 8'hA5,
  parameter logic [7:0]  RESET_VAL = 8'h00
) (
  input  logic                      spi_wb_clk_i,
  input  logic                      spi_wb_rst_i,
  input  logic                      sck_i,
  input  logic                      cs_n_i,
  input  logic                      mosi_i,
  output logic                      miso_o,
  output logic                      miso_oe_o,
  output logic [8*(2**ADDR_W)-1:0]  regs_o,
  output logic                      wr_stb_o,
  output logic [ADDR_W-1:0]         wr_addr_o,
  output logic                      busy_o
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

  // Synchronizers plus one history flop each
  logic sck_s1, sck_s2, sck_h;
  logic cs_s1, cs_s2, cs_h;
  logic mosi_s1, mosi_s2, mosi_h;

  logic sck_rise, sck_fall, cs_fall;

  state_e            state_q, state_d;
  logic [7:0]        tx_q, tx_d;
  logic [6:0]        rx_q, rx_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic              loaded_q, loaded_d;
  logic              wr_stb_q, wr_stb_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [1:0]        init_q;
  logic              armed_q;
  logic              reg_we;
  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        regs_q [NREGS];

  assign sck_rise = sck_s2 & ~sck_h;
  assign sck_fall = ~sck_s2 & sck_h;
  assign cs_fall  = ~cs_s2 & cs_h;
  assign rx_byte  = {rx_q, mosi_h};
  assign cmd_addr = rx_byte[ADDR_W-1:0];

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    loaded_d  = loaded_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    reg_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cs_fall && armed_q) begin
          state_d  = StCmd;
          tx_d     = ID_BYTE;
          cnt_d    = 3'd0;
          loaded_d = 1'b0;
        end
      end
      StCmd, StData: begin
        // CS deassertion wins over any simultaneous SCK edge
        if (cs_s2) begin
          state_d = StIdle;
        end else if (sck_rise) begin
          rx_d  = rx_byte[6:0];
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            loaded_d = 1'b1;
            if (state_q == StCmd) begin
              state_d = StData;
              rw_d    = rx_byte[7];
              if (rx_byte[7]) begin
                tx_d   = regs_q[cmd_addr];
                addr_d = cmd_addr + ADDR_W'(1);
              end else begin
                tx_d   = 8'h00;
                addr_d = cmd_addr;
              end
            end else if (rw_q) begin
              tx_d   = regs_q[addr_q];
              addr_d = addr_q + ADDR_W'(1);
            end else begin
              reg_we    = 1'b1;
              wr_stb_d  = 1'b1;
              wr_addr_d = addr_q;
              addr_d    = addr_q + ADDR_W'(1);
              tx_d      = 8'h00;
            end
          end
        end else if (sck_fall) begin
          // A freshly loaded byte already presents its MSB
          if (loaded_q) begin
            loaded_d = 1'b0;
          end else begin
            tx_d = {tx_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge spi_wb_clk_i) begin
    if (spi_wb_rst_i) begin
      sck_s1    <= 1'b0;
      sck_s2    <= 1'b0;
      sck_h     <= 1'b0;
      cs_s1     <= 1'b1;
      cs_s2     <= 1'b1;
      cs_h      <= 1'b1;
      mosi_s1   <= 1'b0;
      mosi_s2   <= 1'b0;
      mosi_h    <= 1'b0;
      state_q   <= StIdle;
      tx_q      <= 8'h00;
      rx_q      <= 7'h00;
      cnt_q     <= 3'd0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      loaded_q  <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      init_q    <= 2'd0;
      armed_q   <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else begin
      sck_s1    <= sck_i;
      sck_s2    <= sck_s1;
      sck_h     <= sck_s2;
      cs_s1     <= cs_n_i;
      cs_s2     <= cs_s1;
      cs_h      <= cs_s2;
      mosi_s1   <= mosi_i;
      mosi_s2   <= mosi_s1;
      mosi_h    <= mosi_s2;
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      loaded_q  <= loaded_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      // Only accept a CS fall after CS has been seen high with real pin data
      // in the synchronizer, so a frame interrupted by reset is ignored.
      if (init_q != 2'd2) begin
        init_q <= init_q + 2'd1;
      end
      if (init_q == 2'd2 && cs_s2) begin
        armed_q <= 1'b1;
      end
      if (reg_we) begin
        regs_q[addr_q] <= rx_byte;
      end
    end
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_regs
    assign regs_o[8*i +: 8] = regs_q[i];
  end

  assign miso_o    = (state_q != StIdle) & tx_q[7];
  assign miso_oe_o = (state_q != StIdle);
  assign busy_o    = (state_q != StIdle);
  assign wr_stb_o  = wr_stb_q;
  assign wr_addr_o = wr_addr_q;

endmodule

// File: tb/tb_spi_target_regs.sv
// Scoreboard bench for spi_target_regs: a mode-0 master task drives frames at
// clk/8, expected MISO bytes and writes are queued and checked by a monitor.
module tb_spi_target_regs;

  localparam int unsigned ADDR_W = 2;

  logic        clk = 1'b0;
  logic        rst, sck, cs_n, mosi;
  logic        miso, miso_oe, wr_stb, busy;
  logic [31:0] regs;
  logic [1:0]  wr_addr;

  always #5 clk = ~clk;

  spi_target_regs #(
    .ADDR_W   (ADDR_W),
    .ID_BYTE  (8'hA5),
    .RESET_VAL(8'h00)
  ) dut (
    .spi_wb_clk_i(clk),
    .spi_wb_rst_i(rst),
    .sck_i       (sck),
    .cs_n_i      (cs_n),
    .mosi_i      (mosi),
    .miso_o      (miso),
    .miso_oe_o   (miso_oe),
    .regs_o      (regs),
    .wr_stb_o    (wr_stb),
    .wr_addr_o   (wr_addr),
    .busy_o      (busy)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  exp_miso[$];
  logic [7:0]  obs_miso[$];
  logic [9:0]  exp_wr[$];
  logic [7:0]  fb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: consume DUT write strobes and received MISO bytes
  logic [9:0] mon_e;
  logic [7:0] mon_o;
  always @(negedge clk) begin
    if (wr_stb) begin
      if (exp_wr.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_wr_stb: got addr %0h data %0h, expected no strobe",
                 wr_addr, regs[8*wr_addr +: 8]);
      end else begin
        mon_e = exp_wr.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(mon_e[9:8]));
        chk("wr_data", 32'(regs[8*wr_addr +: 8]), 32'(mon_e[7:0]));
      end
    end
    if (obs_miso.size() != 0) begin
      mon_o = obs_miso.pop_front();
      if (exp_miso.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_miso_byte: got %0h, expected none", mon_o);
      end else begin
        chk("miso_byte", 32'(mon_o), 32'(exp_miso.pop_front()));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bit(input logic b, output logic r);
    mosi = b;
    tick(4);
    r = miso;
    sck = 1'b1;
    tick(4);
    sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx);
    logic [7:0] r;
    logic       rb;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], rb);
      r[i] = rb;
    end
    obs_miso.push_back(r);
  endtask

  task automatic cs_lo();
    cs_n = 1'b0;
    tick(2);
  endtask

  task automatic cs_hi();
    tick(4);
    cs_n = 1'b1;
    tick(8);
  endtask

  task automatic frame();
    cs_lo();
    foreach (fb[i]) spi_byte(fb[i]);
    cs_hi();
  endtask

  initial begin
    logic       rb;
    logic [1:0] a;
    logic [7:0] d;
    rst = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_regs", regs, 32'h0);
    chk("rst_miso_oe", 32'(miso_oe), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wr_stb", 32'(wr_stb), 0);
    chk("rst_miso", 32'(miso), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    tick(4);

    // Write burst
    exp_miso.push_back(8'hA5); exp_miso.push_back(8'h00); exp_miso.push_back(8'h00);
    exp_wr.push_back({2'd1, 8'h3C}); exp_wr.push_back({2'd2, 8'h5A});
    fb = '{8'h01, 8'h3C, 8'h5A};
    frame();
    chk("burst_reg1", 32'(regs[15:8]), 32'h3C);
    chk("burst_reg2", 32'(regs[23:16]), 32'h5A);
    chk("burst_busy", 32'(busy), 0);

    // Preload with a wrapping write, then read back with wrap
    exp_miso.push_back(8'hA5);
    for (int i = 0; i < 3; i++) exp_miso.push_back(8'h00);
    exp_wr.push_back({2'd3, 8'h11});
    exp_wr.push_back({2'd0, 8'h22});
    exp_wr.push_back({2'd1, 8'h33});
    fb = '{8'h03, 8'h11, 8'h22, 8'h33};
    frame();
    exp_miso.push_back(8'hA5); exp_miso.push_back(8'h11);
    exp_miso.push_back(8'h22); exp_miso.push_back(8'h33);
    fb = '{8'h83, 8'hFF, 8'hFF, 8'hFF};
    frame();

    // Abort mid-byte
    cs_lo();
    exp_miso.push_back(8'hA5);
    spi_byte(8'h00);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, rb);
    cs_hi();
    chk("abort_reg0", 32'(regs[7:0]), 32'h22);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_miso_oe", 32'(miso_oe), 0);
    exp_miso.push_back(8'hA5); exp_miso.push_back(8'h00);
    exp_wr.push_back({2'd0, 8'h77});
    fb = '{8'h00, 8'h77};
    frame();
    chk("after_abort_reg0", 32'(regs[7:0]), 32'h77);

    // Reset mid-frame with CS held low
    cs_lo();
    exp_miso.push_back(8'hA5);
    spi_byte(8'h02);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    exp_miso.push_back(8'h00); exp_miso.push_back(8'h00);
    spi_byte(8'hAA);
    spi_byte(8'hBB);
    @(negedge clk);
    chk("midrst_miso_oe", 32'(miso_oe), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_regs", regs, 32'h0);
    cs_hi();
    exp_miso.push_back(8'hA5); exp_miso.push_back(8'h00);
    exp_wr.push_back({2'd2, 8'hC3});
    fb = '{8'h02, 8'hC3};
    frame();
    exp_miso.push_back(8'hA5); exp_miso.push_back(8'hC3);
    fb = '{8'h82, 8'h00};
    frame();

    // Random write/read-back pairs at clk/8
    for (int k = 0; k < 16; k++) begin
      a = 2'($urandom_range(0, 3));
      d = 8'($urandom_range(0, 255));
      exp_miso.push_back(8'hA5); exp_miso.push_back(8'h00);
      exp_wr.push_back({a, d});
      fb = '{{6'b0, a}, d};
      frame();
      exp_miso.push_back(8'hA5); exp_miso.push_back(d);
      fb = '{{6'b100000, a}, 8'h00};
      frame();
    end

    tick(10);
    chk("pending_miso", 32'(exp_miso.size()), 0);
    chk("pending_wr", 32'(exp_wr.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_target_regs.md
# spi_target_regs

SPI target (responder) for the SPI master in the I2C-to-SPI bridge, used as the bench/peer device on the far end of `sck_o`/`mosi_o`/`miso_i`. It oversamples the SPI pins in the system clock domain, decodes a command byte, and gives burst read/write access to a small register file. The register contents are also exported in parallel for on-chip observation.

## Interface

Parameters:
- `ADDR_W`, 2: register address width; `NREGS = 2**ADDR_W` 8-bit registers.
- `ID_BYTE`, 8'hA5: byte shifted out on MISO during the command byte.
- `RESET_VAL`, 8'h00: reset value of every register.

Ports:
- `spi_wb_clk_i`  in  1: system clock; the only clock.
- `spi_wb_rst_i`  in  1: reset, synchronous, active-high.
- `sck_i`  in  1: SPI clock from the master, asynchronous. Mode 0 (CPOL=0, CPHA=0).
- `cs_n_i`  in  1: chip select, active-low, asynchronous.
- `mosi_i`  in  1: master-out data, asynchronous.
- `miso_o`  out  1: target-out data.
- `miso_oe_o`  out  1: MISO drive enable; high only while a frame is active.
- `regs_o`  out  8*NREGS: register file, reg0 in bits [7:0].
- `wr_stb_o`  out  1: one-cycle pulse per completed register write.
- `wr_addr_o`  out  ADDR_W: address of the write flagged by `wr_stb_o`.
- `busy_o`  out  1: high while state is not IDLE.

## Operation

Synchronizers and edge detection:
- `sck_i`, `cs_n_i` and `mosi_i` each pass through a 2-flop synchronizer, then one history flop for edge detection.
- Synchronizer reset values: sck 0, cs_n 1, mosi 0.

Frame format:
- Byte 0 is the command byte: bit7 is RW (1 = read); bits[ADDR_W-1:0] are the start address; other bits are ignored.
- Following bytes are data. The address auto-increments after every data byte and wraps modulo NREGS.
- All bytes are MSB first.

States:
- IDLE: waiting for a synced CS falling edge. On that edge, load `tx_sr` with `ID_BYTE`, clear the bit counter, go to CMD.
- CMD: on each synced SCK rising edge, shift `mosi` into `rx_sr`. On the 8th bit, latch RW and address, then go to DATA.
  - Read: load `tx_sr` with reg[addr] and increment addr.
  - Write: load `tx_sr` with 8'h00.
- DATA: on the 8th bit of each byte:
  - Write: reg[addr] <= `rx_sr` byte; pulse `wr_stb_o` with `wr_addr_o` = addr; addr++. `tx_sr` gets 8'h00.
  - Read: `tx_sr` <= reg[addr]; addr++. MOSI data is ignored.
- From any state, a synced CS rising edge (or CS high) returns to IDLE. A partial byte is discarded with no write and no strobe.

MISO:
- `miso_o` = `tx_sr[7]` whenever not IDLE; otherwise 0.
- On each synced SCK falling edge, `tx_sr` shifts left. The exception is a falling edge that follows a byte-completing rising edge: the freshly loaded byte's MSB is already at bit 7, so no shift happens.
- `miso_oe_o` = (state != IDLE).

Simultaneous events:
- A CS rising edge and an SCK edge in the same cycle: the CS rising edge wins, and the SCK edge is ignored.
- A CS falling edge and an SCK rising edge in the same cycle: the frame starts and the edge is not counted. The master must not do this; this rule only makes the behaviour defined.

Reset:
- Sets all registers to `RESET_VAL`, the state to IDLE, addr and bit counter to 0, and `wr_stb_o` to 0.
- Reset mid-frame with CS still low: the block stays IDLE until a new synced CS falling edge. The remainder of the interrupted frame is ignored.

## Timing

- Reset values: `miso_o` 0, `miso_oe_o` 0, `wr_stb_o` 0, `wr_addr_o` 0, `busy_o` 0, `regs_o` all `RESET_VAL`.
- Pin-to-internal-edge latency is 3 clocks (2 sync flops + history flop).
- `miso_o` changes at most 4 clocks after an SCK falling edge at the pin.
- `miso_oe_o` rises at most 4 clocks after the CS falling edge at the pin.
- A register update and `wr_stb_o` happen 1 clock after the internal 8th rising edge is detected. `regs_o` shows the new value in the same cycle that `wr_stb_o` is high.
- Required: each SCK high and low phase lasts ≥ 4 clocks (SCK ≤ clk/8). CS setup to the first SCK rising edge is ≥ 4 clocks; CS hold after the last SCK falling edge is ≥ 4 clocks.
- No back-pressure; a frame may be any length.

## Test plan

- Reset: drive `spi_wb_rst_i` 1 for 2 clocks -> all `regs_o` 8'h00, `miso_oe_o`/`busy_o`/`wr_stb_o` 0, `miso_o` 0.
- Write burst: CS low, send 8'h01, 8'h3C, 8'h5A, CS high, SCK = clk/8 ->
  - MISO returns 8'hA5 during the command byte, then 8'h00 during the data bytes.
  - reg1=8'h3C, reg2=8'h5A; two `wr_stb_o` pulses with `wr_addr_o` 1 then 2.
- Read with wrap: preload reg3=8'h11, reg0=8'h22, reg1=8'h33; send 8'h83 plus 3 dummy bytes -> MISO bytes A5, 11, 22, 33; no `wr_stb_o`.
- Abort mid-byte: send 8'h00, then 4 bits of 8'hFF, then CS high -> reg0 unchanged, no strobe, `busy_o` 0. A following full write of 8'h00, 8'h77 sets reg0=8'h77.
- Reset mid-frame: assert reset after the command byte 8'h02 while CS stays low, clock 2 more bytes -> reg2 stays 8'h00, `miso_oe_o` 0. A new frame after CS toggles works normally.
- Ratio limit: SCK at exactly clk/8 with 16 random write/read-back pairs -> all read data match the written data.
